// File: rtl/hmmm_pkg.sv
// Shared types for the hmmm core: opcodes, FSM states and the branch condition decode.
package hmmm_pkg;

  typedef enum logic [3:0] {
    OP_LOADN   = 4'h0,
    OP_HALT    = 4'h1,
    OP_STORER  = 4'h2,
    OP_LOADR   = 4'h3,
    OP_COPY    = 4'h4,
    OP_NEG     = 4'h5,
    OP_ADD     = 4'h6,
    OP_SUB     = 4'h7,
    OP_JEQZN   = 4'h8,
    OP_JNEZN   = 4'h9,
    OP_JGTZN   = 4'hA,
    OP_JLTZN   = 4'hB,
    OP_JUMPN_C = 4'hC,
    OP_JUMPN_D = 4'hD,
    OP_JUMPR   = 4'hE,
    OP_JUMPN_F = 4'hF
  } op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // Branch decision from the rd value's zero and sign flags.
  function automatic logic branch_taken(input op_e op, input logic is_zero, input logic is_neg);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JEQZN:   taken = is_zero;
      OP_JNEZN:   taken = !is_zero;
      OP_JGTZN:   taken = !is_neg && !is_zero;
      OP_JLTZN:   taken = is_neg;
      OP_JUMPN_C,
      OP_JUMPN_D,
      OP_JUMPN_F,
      OP_JUMPR:   taken = 1'b1;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// NREG x DW register file: three combinational reads, one synchronous write, r0 hardwired to zero.
module hmmm_regfile
  import hmmm_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  localparam int unsigned RAW = $clog2(NREG)
) (
  input  logic           ph1,
  input  logic           reset,
  input  logic [RAW-1:0] ra_addr,
  input  logic [RAW-1:0] rb_addr,
  input  logic [RAW-1:0] rd_addr,
  output logic [DW-1:0]  ra_data,
  output logic [DW-1:0]  rb_data,
  output logic [DW-1:0]  rd_data,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Index 0 never holds a written value, but the read is still forced for clarity of intent.
  always_comb begin
    ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
    rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];
    rd_data = (rd_addr == '0) ? '0 : regs_q[rd_addr];
  end

endmodule

// File: rtl/hmmm_core.sv
// Multi-cycle hmmm CPU: FETCH/EXEC/MEM/HALT sequencer with stallable instruction and data ports.
module hmmm_core
  import hmmm_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 8,
  localparam int unsigned RAW = $clog2(NREG),
  localparam int unsigned IW  = 4 + RAW + DW
) (
  input  logic          ph1,
  input  logic          reset,
  output logic          imem_req,
  output logic [DW-1:0] imem_addr,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic          halted,
  output logic          retire
);

  state_e         state_q, state_d;
  logic [DW-1:0]  pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;

  op_e            op;
  logic [RAW-1:0] rd_idx, ra_idx, rb_idx;
  logic [DW-1:0]  imm;
  logic [DW-1:0]  ra_data, rb_data, rd_data;
  logic           rf_we;
  logic [DW-1:0]  rf_wdata;
  logic           is_mem_op;
  logic           taken;

  assign op        = op_e'(ir_q[IW-1 -: 4]);
  assign rd_idx    = ir_q[IW-5 -: RAW];
  assign imm       = ir_q[DW-1:0];
  assign ra_idx    = imm[DW-1 -: RAW];
  assign rb_idx    = imm[DW-1-RAW -: RAW];
  assign is_mem_op = (op == OP_STORER) || (op == OP_LOADR);
  assign taken     = branch_taken(op, rd_data == '0, rd_data[DW-1]);

  hmmm_regfile #(.DW(DW), .NREG(NREG)) u_rf (
    .ph1     (ph1),
    .reset   (reset),
    .ra_addr (ra_idx),
    .rb_addr (rb_idx),
    .rd_addr (rd_idx),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .rd_data (rd_data),
    .we      (rf_we),
    .waddr   (rd_idx),
    .wdata   (rf_wdata)
  );

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (imem_ready) state_d = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_HALT)  state_d = ST_HALT;
        else if (is_mem_op) state_d = ST_MEM;
        else                state_d = ST_FETCH;
      end
      ST_MEM:   if (dmem_ready) state_d = ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  // PC, IR and register-write decode; all updates land on the completing edge.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state_q)
      ST_FETCH: if (imem_ready) ir_d = imem_rdata;
      ST_EXEC: begin
        case (op)
          OP_LOADN: begin rf_we = 1'b1; rf_wdata = imm;               end
          OP_COPY:  begin rf_we = 1'b1; rf_wdata = rb_data;           end
          OP_NEG:   begin rf_we = 1'b1; rf_wdata = '0 - rb_data;      end
          OP_ADD:   begin rf_we = 1'b1; rf_wdata = ra_data + rb_data; end
          OP_SUB:   begin rf_we = 1'b1; rf_wdata = ra_data - rb_data; end
          default:  rf_we = 1'b0;
        endcase
        if (op[3] && taken) begin
          pc_d = (op == OP_JUMPR) ? rd_data : imm;
        end else if ((op != OP_HALT) && !is_mem_op) begin
          pc_d = pc_q + DW'(1);
        end
      end
      ST_MEM: begin
        if (dmem_ready) begin
          pc_d = pc_q + DW'(1);
          if (op == OP_LOADR) begin
            rf_we    = 1'b1;
            rf_wdata = dmem_rdata;
          end
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // Outputs decode the current state; reset masks the strobes immediately.
  always_comb begin
    imem_req   = (state_q == ST_FETCH) && !reset;
    imem_addr  = pc_q;
    dmem_req   = (state_q == ST_MEM) && !reset;
    dmem_we    = (state_q == ST_MEM) && (op == OP_STORER) && !reset;
    dmem_addr  = rb_data;
    dmem_wdata = rd_data;
    halted     = (state_q == ST_HALT) && !reset;
    retire     = !reset &&
                 (((state_q == ST_EXEC) && (op != OP_HALT) && !is_mem_op) ||
                  ((state_q == ST_MEM) && dmem_ready));
  end

endmodule

// File: tb/tb_hmmm_core.sv
// Directed bench for hmmm_core: table of small programs on an 8-bit core plus reset and 16-bit sequences.
module tb_hmmm_core;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 15;
  localparam int unsigned IW16 = 24;
  localparam logic [IW-1:0] HLT = {4'h1, 11'h000};

  typedef logic [7:0][IW-1:0] prog_t;

  typedef struct {
    string       name;
    prog_t       prog;
    logic [IW-1:0] w_ff;
    int          iwait;
    int          dwait;
    bit          stray;
    int          cycles;
    int          retires;
    logic [7:0]  pc;
    int          chk_reg;
    logic [7:0]  chk_val;
    int          stores;
    logic [7:0]  st_addr;
    logic [7:0]  st_data;
    int          we_cyc;
  } vec_t;

  logic ph1 = 1'b0;
  logic reset = 1'b1;
  always #5 ph1 = ~ph1;

  logic          imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, halted, retire;
  logic [DW-1:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic [IW-1:0] imem_rdata;

  logic          imem16_req, imem16_ready, dmem16_req, dmem16_we, dmem16_ready, halted16, retire16;
  logic [15:0]   imem16_addr, dmem16_addr, dmem16_wdata, dmem16_rdata;
  logic [IW16-1:0] imem16_rdata;

  hmmm_core #(.DW(8), .NREG(8)) u_dut (
    .ph1(ph1), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .halted(halted), .retire(retire)
  );

  hmmm_core #(.DW(16), .NREG(16)) u_dut16 (
    .ph1(ph1), .reset(reset),
    .imem_req(imem16_req), .imem_addr(imem16_addr), .imem_ready(imem16_ready), .imem_rdata(imem16_rdata),
    .dmem_req(dmem16_req), .dmem_we(dmem16_we), .dmem_addr(dmem16_addr), .dmem_wdata(dmem16_wdata),
    .dmem_ready(dmem16_ready), .dmem_rdata(dmem16_rdata), .halted(halted16), .retire(retire16)
  );

  // Memory models with programmable wait states and optional stray ready.
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;
  bit stray = 1'b0;
  logic [IW-1:0] imem [256];
  logic [DW-1:0] dmem [256];

  always @(posedge ph1) begin
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  assign imem_ready = stray || (imem_req && (icnt >= iwait));
  assign dmem_ready = stray || (dmem_req && (dcnt >= dwait));
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  // 16-bit core: LOADN r15,0xBEEF; NEG r14,r15; HALT. Its program never loads, so rdata is a don't-care echo.
  assign imem16_ready = imem16_req;
  assign dmem16_ready = dmem16_req;
  assign dmem16_rdata = dmem16_addr ^ dmem16_wdata ^ {15'h0, dmem16_we};
  assign imem16_rdata = (imem16_addr == 16'd0) ? {4'h0, 4'd15, 16'hBEEF} :
                        (imem16_addr == 16'd1) ? {4'h5, 4'd14, 4'd0, 4'd15, 8'h00} :
                                                 {4'h1, 20'h00000};

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [IW-1:0] e_ld(input int rd, input int imm);
    return {4'h0, 3'(rd), 8'(imm)};
  endfunction

  function automatic logic [IW-1:0] e_rr(input logic [3:0] op, input int rd, input int ra, input int rb);
    return {op, 3'(rd), 3'(ra), 3'(rb), 2'b00};
  endfunction

  function automatic logic [IW-1:0] e_br(input logic [3:0] op, input int rd, input int tgt);
    return {op, 3'(rd), 8'(tgt)};
  endfunction

  function automatic prog_t pk8(input logic [IW-1:0] w0, w1, w2, w3, w4, w5, w6, w7);
    prog_t p;
    p[0] = w0; p[1] = w1; p[2] = w2; p[3] = w3;
    p[4] = w4; p[5] = w5; p[6] = w6; p[7] = w7;
    return p;
  endfunction

  function automatic vec_t mk(input string name, input int iw, input int dw, input bit st,
                              input int cyc, input int ret, input int pc, input int creg,
                              input int cval, input int nst, input int sa, input int sd, input int wec);
    vec_t v;
    v.name = name; v.prog = '0; v.w_ff = HLT;
    v.iwait = iw; v.dwait = dw; v.stray = st;
    v.cycles = cyc; v.retires = ret; v.pc = 8'(pc);
    v.chk_reg = creg; v.chk_val = 8'(cval);
    v.stores = nst; v.st_addr = 8'(sa); v.st_data = 8'(sd); v.we_cyc = wec;
    return v;
  endfunction

  task automatic load_prog(input prog_t p, input logic [IW-1:0] w_ff);
    for (int a = 0; a < 256; a++) imem[a] = HLT;
    for (int a = 0; a < 8; a++) imem[a] = p[a];
    imem[255] = w_ff;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, ret, nst, wec, viol;
    logic pis, pds, pdwe;
    logic [7:0] pia, pda, pdw, sa, sd;
    @(negedge ph1);
    reset = 1'b1;
    load_prog(v.prog, v.w_ff);
    iwait = v.iwait; dwait = v.dwait; stray = v.stray;
    @(negedge ph1);
    @(negedge ph1);
    reset = 1'b0;
    cyc = 0; ret = 0; nst = 0; wec = 0; viol = 0;
    pis = 1'b0; pds = 1'b0; pdwe = 1'b0; pia = '0; pda = '0; pdw = '0; sa = '0; sd = '0;
    forever begin
      #1;
      if (halted || cyc >= 200) break;
      if (pis && (imem_addr != pia)) viol++;
      if (pds && ((dmem_addr != pda) || (dmem_wdata != pdw) || (dmem_we != pdwe))) viol++;
      if (retire) ret++;
      if (dmem_req && dmem_we) wec++;
      if (dmem_req && dmem_ready && dmem_we) begin nst++; sa = dmem_addr; sd = dmem_wdata; end
      pis = imem_req && !imem_ready; pia = imem_addr;
      pds = dmem_req && !dmem_ready; pda = dmem_addr; pdw = dmem_wdata; pdwe = dmem_we;
      @(negedge ph1);
      cyc++;
    end
    chk({v.name, ".cycles"}, 32'(cyc), 32'(v.cycles));
    chk({v.name, ".retire"}, 32'(ret), 32'(v.retires));
    chk({v.name, ".halt_pc"}, 32'(imem_addr), 32'(v.pc));
    chk({v.name, ".reg"}, 32'(u_dut.u_rf.regs_q[3'(v.chk_reg)]), 32'(v.chk_val));
    chk({v.name, ".stores"}, 32'(nst), 32'(v.stores));
    chk({v.name, ".we_cycles"}, 32'(wec), 32'(v.we_cyc));
    chk({v.name, ".stable"}, 32'(viol), 32'd0);
    if (v.stores > 0) begin
      chk({v.name, ".st_addr"}, 32'(sa), 32'(v.st_addr));
      chk({v.name, ".st_data"}, 32'(sd), 32'(v.st_data));
    end
  endtask

  vec_t vecs[7];

  initial begin
    int cyc;
    vecs[0] = mk("alu",    0, 0, 1'b0,  8, 3, 8'h03, 3, 8'h02, 0, 0, 0, 0);
    vecs[0].prog = pk8(e_ld(1, 5), e_ld(2, 3), e_rr(4'h7, 3, 1, 2), HLT, HLT, HLT, HLT, HLT);
    vecs[1] = mk("istall", 3, 0, 1'b0, 20, 3, 8'h03, 3, 8'h02, 0, 0, 0, 0);
    vecs[1].prog = vecs[0].prog;
    vecs[2] = mk("stray",  0, 0, 1'b1,  8, 3, 8'h03, 3, 8'h02, 0, 0, 0, 0);
    vecs[2].prog = vecs[0].prog;
    vecs[3] = mk("mem",    0, 2, 1'b0, 16, 4, 8'h04, 4, 8'h05, 1, 3, 5, 3);
    vecs[3].prog = pk8(e_ld(1, 5), e_ld(2, 3), e_rr(4'h2, 1, 0, 2), e_rr(4'h3, 4, 0, 2),
                       HLT, HLT, HLT, HLT);
    vecs[4] = mk("branch", 0, 0, 1'b0, 12, 5, 8'h10, 5, 8'h10, 0, 0, 0, 0);
    vecs[4].prog = pk8(e_ld(1, 8'h80), e_br(4'hB, 1, 4), HLT, HLT, e_br(4'hA, 1, 7),
                       e_ld(5, 8'h10), e_br(4'hE, 5, 0), HLT);
    vecs[5] = mk("pcwrap", 0, 0, 1'b0, 10, 4, 8'h02, 6, 8'h21, 0, 0, 0, 0);
    vecs[5].prog = pk8(e_br(4'h9, 6, 2), e_br(4'hF, 0, 8'hFF), HLT, HLT, HLT, HLT, HLT, HLT);
    vecs[5].w_ff = e_ld(6, 8'h21);
    vecs[6] = mk("r0wrap", 0, 0, 1'b0, 17, 7, 8'h07, 4, 8'h00, 1, 0, 1, 1);
    vecs[6].prog = pk8(e_ld(0, 7), e_rr(4'h4, 1, 0, 0), e_ld(2, 8'hFF), e_ld(3, 1),
                       e_rr(4'h6, 4, 2, 3), e_rr(4'h5, 5, 0, 2), e_rr(4'h2, 5, 0, 1), HLT);

    // Outputs while reset is held from time zero.
    #2;
    chk("rst.imem_req", 32'(imem_req), 32'd0);
    chk("rst.dmem_req", 32'(dmem_req), 32'd0);
    chk("rst.dmem_we",  32'(dmem_we),  32'd0);
    chk("rst.retire",   32'(retire),   32'd0);
    chk("rst.halted",   32'(halted),   32'd0);
    chk("rst.pc",       32'(imem_addr), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset asserted while a store is waiting on dmem_ready.
    @(negedge ph1);
    reset = 1'b1;
    load_prog(pk8(e_ld(1, 5), e_ld(2, 3), e_ld(7, 9), e_rr(4'h2, 1, 0, 2), HLT, HLT, HLT, HLT), HLT);
    iwait = 0; dwait = 20; stray = 1'b0;
    @(negedge ph1);
    reset = 1'b0;
    cyc = 0;
    #1;
    while (!dmem_req && cyc < 50) begin
      @(negedge ph1);
      #1;
      cyc++;
    end
    chk("midmem.dmem_req", 32'(dmem_req), 32'd1);
    chk("midmem.r7", 32'(u_dut.u_rf.regs_q[7]), 32'h09);
    #2;
    reset = 1'b1;
    #1;
    chk("midmem.req_drop", 32'(dmem_req), 32'd0);
    chk("midmem.we_drop",  32'(dmem_we),  32'd0);
    chk("midmem.ireq",     32'(imem_req), 32'd0);
    dwait = 0;
    @(negedge ph1);
    reset = 1'b0;
    #1;
    chk("midmem.fetch_addr", 32'(imem_addr), 32'd0);
    chk("midmem.fetch_req",  32'(imem_req),  32'd1);
    for (int r = 0; r < NREG; r++) begin
      chk($sformatf("midmem.reg%0d", r), 32'(u_dut.u_rf.regs_q[r]), 32'd0);
    end

    // 16-bit, 16-register build.
    @(negedge ph1);
    reset = 1'b1;
    @(negedge ph1);
    reset = 1'b0;
    repeat (12) @(negedge ph1);
    #1;
    chk("w16.halted", 32'(halted16), 32'd1);
    chk("w16.pc",     32'(imem16_addr), 32'd2);
    chk("w16.r15",    32'(u_dut16.u_rf.regs_q[15]), 32'hBEEF);
    chk("w16.r14",    32'(u_dut16.u_rf.regs_q[14]), 32'h4111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/hmmm_core.md
Name: hmmm_core

Overview:
- Parametrised multi-cycle successor to the 8-bit two-phase processor: configurable data width and register count, single edge-triggered clock.
- Separate instruction and data memory ports, each with a req/ready handshake that stalls the core for any number of wait cycles.
- Adds a HALT instruction, hardwired-zero r0 and a retire strobe for verification.
- Sits as the CPU under the chip top; memories/pads attach to its ports.

Parameters:
DW, 8, data/address width; PC, registers and memory addresses are DW bits
NREG, 8, register count, power of 2 >= 2; RAW = clog2(NREG)
IW, 4+RAW+DW, instruction width (derived; not overridable)

Ports:
ph1  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-high
imem_req  output  1  instruction fetch request
imem_addr  output  DW  fetch address (= PC)
imem_ready  input  1  fetch data valid this cycle
imem_rdata  input  IW  instruction word
dmem_req  output  1  data access request
dmem_we  output  1  1=store, 0=load; valid with dmem_req
dmem_addr  output  DW  data address
dmem_wdata  output  DW  store data
dmem_ready  input  1  access complete this cycle (load data valid)
dmem_rdata  input  DW  load data
halted  output  1  core in HALT state
retire  output  1  one-cycle pulse when an instruction completes

Behaviour:
- Instruction fields: op = [IW-1 -: 4]; rd = next RAW bits; imm = [DW-1:0]; ra = imm[DW-1 -: RAW]; rb = imm[DW-1-RAW -: RAW].
- Opcodes:
  - 0000 LOADN: rd=imm
  - 0001 HALT
  - 0010 STORER: mem[rb]=rd
  - 0011 LOADR: rd=mem[rb]
  - 0100 COPY: rd=rb
  - 0101 NEG: rd=-rb
  - 0110 ADD: rd=ra+rb
  - 0111 SUB: rd=ra-rb
  - 1000 JEQZN, 1001 JNEZN, 1010 JGTZN, 1011 JLTZN: if cond on rd, PC=imm
  - 1100, 1101, 1111 JUMPN: PC=imm
  - 1110 JUMPR: PC=rd
- Conditions: zero = (rd==0); JGTZN = rd[DW-1]==0 & rd!=0; JLTZN = rd[DW-1]==1.
- Arithmetic is modulo 2^DW; no flags are stored.
- r0 reads as 0; writes to r0 are discarded.
- FSM states are FETCH, EXEC, MEM, HALT.
  - FETCH: imem_req=1, imem_addr=PC. On imem_ready, latch imem_rdata into IR and go to EXEC. Otherwise stay; PC and IR hold.
  - EXEC: decode IR.
    - ALU ops and LOADN write rd.
    - Branches load PC with the target when taken; all other completing instructions set PC=PC+1 (wraps 2^DW-1 -> 0).
    - ALU, LOADN and branch instructions pulse retire and go to FETCH.
    - LOADR/STORER go to MEM.
    - HALT goes to HALT; PC is not incremented.
  - MEM: dmem_req=1, dmem_addr=R[rb], dmem_we=(op==STORER), dmem_wdata=R[rd]. These hold stable until dmem_ready. On dmem_ready, LOADR writes rd with dmem_rdata, PC=PC+1, retire=1, go to FETCH.
  - HALT: halted=1, all requests 0. Exit only by reset.
- Latency with zero-wait memory: ALU/branch = 2 cycles; load/store = 3 cycles. Each wait cycle adds 1.
- A ready input outside its matching request is ignored.
- Reset (asynchronous, any state, including mid-handshake):
  - state=FETCH, PC=0, IR=0, all registers=0.
  - imem_req, dmem_req, dmem_we, retire and halted = 0 while reset is high.
  - Fetch of address 0 begins in the first cycle after reset falls.
- Register write and PC update occur on the same edge as the completing state's transition. A read of rd in the following instruction sees the new value.

Decomposition:
- Package hmmm_pkg holds the opcode enum (4-bit), the FSM state enum, and the condition-code function.
- Sub-module hmmm_regfile: NREG x DW, 2 asynchronous read ports plus a third read for rd, 1 synchronous write port, r0 forced 0, asynchronous reset to 0.

Test Plan:
- Zero-wait program with DW=8, NREG=8: LOADN r1,5; LOADN r2,3; SUB r3,r1,r2; HALT -> r3=2, retire pulses every 2 cycles, halted=1 with PC=3.
- Stalls: same program with imem_ready delayed 3 cycles per fetch -> identical results; imem_addr stable while stalled; retire count=3.
- Memory: STORER r1->[r2] then LOADR r4<-[r2] with dmem_ready delayed 2 cycles -> dmem_we=1 only for the store; dmem_addr=3, wdata=5 held during wait; r4=5.
- Branches: r1=0x80 -> JLTZN taken, JGTZN not taken; JUMPR r5=0x10 -> next imem_addr=0x10; JUMPN 0xFF then fall-through -> PC wraps 0xFF->0x00.
- r0 and wrap: LOADN r0,7 then COPY r1,r0 -> r1=0; ADD with 0xFF+0x01 -> 0x00.
- Reset mid-MEM with dmem_req high -> dmem_req drops immediately; after release, imem_addr=0 and all registers read 0.
- Parameter sweep DW=16, NREG=16: LOADN r15,0xBEEF; NEG r14,r15 -> r14=0x4111.
